alu_srcb_stage: RTL and testbench
=================================

// Module: alu_srcb_stage
// PURPOSE
//  Registered, parametrised ALU operand-B source stage for the CPU datapath.
//  Selects rt, the PC increment constant, sign-extended immediate or
//  sign-extended immediate <<2, then holds the result in a 2-entry skid buffer
//  with valid/ready handshake so the ALU can stall without losing a beat.
// PARAMETERS
//  DATA_W    32  operand width; must satisfy DATA_W >= IMM_W+2
//  IMM_W     16  immediate field width
//  CONST_INC 4   constant driven for select code 001
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  flush      in   1       synchronous: drop all buffered beats
//  in_valid   in   1       upstream beat present
//  in_ready   out  1       stage can accept a beat this cycle
//  src_sel    in   3       000 rt, 001 CONST_INC, 010 SE(imm), 011 SE(imm)<<2, 1xx see CONFIGURATION
//  rt_data    in   DATA_W  register-file rt value
//  imm        in   IMM_W   instruction immediate
//  out_valid  out  1       out_data is valid
//  out_ready  in   1       downstream (ALU) consumes out_data
//  out_data   out  DATA_W  selected operand B
//  sel_err    out  1       registered 1-cycle pulse: unsupported src_sel accepted
// BEHAVIOUR
//  - Reset (reset_n low, async): main/skid valid=0, data=0, sel_err=0;
//    in_ready=1, out_valid=0, out_data=0 while and after reset.
//  - Select computed combinationally from inputs; SE = sign-extend imm to
//    DATA_W; <<2 truncated to DATA_W (upper bits dropped, no saturation).
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  - Latency 1 cycle: beat accepted at edge N appears on out_data after N.
//    Throughput 1 beat/cycle while out_ready stays high.
//  - Main register drives outputs. Skid holds one extra beat.
//  - in_ready = !skid_valid (registered, no comb path from out_ready).
//  - Accept with main empty, or main popping and skid empty -> load main.
//  - Accept with main full and not popping -> load skid; in_ready low next cycle.
//  - Pop with skid full -> main <= skid, skid empties (accept impossible then).
//  - Pop with skid empty and no accept -> main empties.
//  - Order strictly preserved; out_data stable while out_valid & !out_ready.
//  - flush: both valids cleared at edge; a beat accepted in the same cycle is
//    dropped; flush overrides accept/pop; sel_err not raised for dropped beat.
//  - Reset mid-transfer discards all beats immediately.
// CONFIGURATION
//  LUI_SEL_EN defined: src_sel 100 = {imm, (DATA_W-IMM_W) zeros}; 101..111
//    treated as 000 (rt) and pulse sel_err on accept.
//  LUI_SEL_EN undefined: all 1xx codes treated as 000 and pulse sel_err.
// TESTING
//  - Reset: hold reset_n=0 mid-stream -> out_valid=0, out_data=0, in_ready=1
//    asynchronously.
//  - Select: imm=16'h8001, sel=010 -> 32'hFFFF8001; sel=011 -> 32'hFFFE0004;
//    sel=001 -> 32'd4; sel=000 rt=32'h1234_5678 -> same, one cycle later.
//  - Back-pressure: stream A,B,C with out_ready=0 -> A held, B in skid,
//    in_ready=0, C not accepted; out_ready=1 -> A,B,C emerge in order.
//  - Flush: main+skid full, assert flush with in_valid=1 -> out_valid=0 next
//    cycle, in_ready=1, no stale beat emerges.
//  - LUI_SEL_EN: imm=16'hABCD, sel=100 -> 32'hABCD0000, sel_err=0;
//    without macro -> rt_data output, sel_err=1 for one cycle.

Source files
------------

// File: rtl/alu_srcb_stage.sv
// ALU operand-B source select followed by a 2-entry skid buffer (valid/ready).
// Optional LUI_SEL_EN macro adds src_sel 100 = {imm, zeros}.
module alu_srcb_stage #(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int CONST_INC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        src_sel,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sel_err
);

  typedef logic [DATA_W-1:0] data_t;

  data_t sel_data, se_imm;
  logic  bad_sel;
  logic  main_valid, skid_valid;
  data_t main_data, skid_data;
  logic  accept, pop;

  assign se_imm = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    sel_data = rt_data;
    bad_sel  = 1'b0;
    case (src_sel)
      3'b000:  sel_data = rt_data;
      3'b001:  sel_data = data_t'(CONST_INC);
      3'b010:  sel_data = se_imm;
      3'b011:  sel_data = {se_imm[DATA_W-3:0], 2'b00};
`ifdef LUI_SEL_EN
      3'b100:  sel_data = {imm, {(DATA_W-IMM_W){1'b0}}};
`endif
      default: begin
        sel_data = rt_data;
        bad_sel  = 1'b1;
      end
    endcase
  end

  // in_ready comes straight from the skid flop, so out_ready never reaches it.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      sel_err    <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= accept & bad_sel;
      if (pop) begin
        if (skid_valid) begin
          // skid full implies in_ready low, so no accept can collide here
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_data <= sel_data;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (!main_valid) begin
        if (accept) begin
          main_data  <= sel_data;
          main_valid <= 1'b1;
        end
      end else if (accept) begin
        skid_data  <= sel_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Self-checking bench for alu_srcb_stage: directed vectors plus random traffic
// against a queue-based reference model.
module tb_alu_srcb_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [2:0]  src_sel;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        in_ready, out_valid, sel_err;
  logic [31:0] out_data;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] q[$];
  logic        exp_err = 1'b0;

  alu_srcb_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_sel(src_sel), .rt_data(rt_data), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [2:0] sel);
`ifdef LUI_SEL_EN
    return sel >= 3'd5;
`else
    return sel >= 3'd4;
`endif
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] sel, input logic [31:0] rt,
                                         input logic [15:0] im);
    logic signed [31:0] se;
    logic [31:0]        z;
    se = $signed(im);
    z  = im;
    case (sel)
      3'd1: return 32'd4;
      3'd2: return se;
      3'd3: return se * 4;
`ifdef LUI_SEL_EN
      3'd4: return z * 32'd65536;
`endif
      default: return rt;
    endcase
  endfunction

  // One clock: update the model with the inputs seen at the edge, then check.
  task automatic tick();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(ref_op(src_sel, rt_data, imm));
      exp_err = acc && is_bad(src_sel);
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("sel_err", 32'(sel_err), 32'(exp_err));
    if (q.size() > 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] rt,
                       input logic [15:0] im);
    in_valid = v; src_sel = s; rt_data = rt; imm = im;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // select vectors
    drive(1'b1, 3'b010, 32'h0, 16'h8001); tick();
    chk("se_imm", out_data, 32'hFFFF8001);
    drive(1'b1, 3'b011, 32'h0, 16'h8001); tick();
    chk("se_imm_sh2", out_data, 32'hFFFE0004);
    drive(1'b1, 3'b001, 32'h0, 16'h8001); tick();
    chk("const_inc", out_data, 32'd4);
    drive(1'b1, 3'b000, 32'h1234_5678, 16'h0); tick();
    chk("rt_pass", out_data, 32'h1234_5678);
    drive(1'b1, 3'b100, 32'h5555_AAAA, 16'hABCD); tick();
`ifdef LUI_SEL_EN
    chk("lui", out_data, 32'hABCD0000);
    chk("lui_err", 32'(sel_err), 32'd0);
`else
    chk("sel100_rt", out_data, 32'h5555_AAAA);
    chk("sel100_err", 32'(sel_err), 32'd1);
`endif
    drive(1'b1, 3'b111, 32'h0BAD_F00D, 16'h0); tick();
    chk("sel111_err", 32'(sel_err), 32'd1);
    chk("sel111_rt", out_data, 32'h0BAD_F00D);
    drive(1'b0, 3'b000, 32'h0, 16'h0); tick();
    chk("err_pulse_end", 32'(sel_err), 32'd0);
    tick();

    // back-pressure A,B,C
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'hAAAA_0001, 16'h0); tick();
    drive(1'b1, 3'd0, 32'hBBBB_0002, 16'h0); tick();
    drive(1'b1, 3'd0, 32'hCCCC_0003, 16'h0); tick();
    chk("bp_hold_a", out_data, 32'hAAAA_0001);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_stable_a", out_data, 32'hAAAA_0001);
    out_ready = 1'b1; tick();
    chk("bp_b", out_data, 32'hBBBB_0002);
    tick();
    chk("bp_c", out_data, 32'hCCCC_0003);
    drive(1'b0, 3'd0, 32'h0, 16'h0); tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // flush with both entries full and a beat offered
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h1111_1111, 16'h0); tick();
    drive(1'b1, 3'd0, 32'h2222_2222, 16'h0); tick();
    drive(1'b1, 3'b111, 32'h3333_3333, 16'h0);
    flush = 1'b1; tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    repeat (3) begin
      tick();
      chk("flush_no_stale", 32'(out_valid), 32'd0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, 16'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;

    // async reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'hDEAD_BEEF, 16'h0); tick();
    drive(1'b1, 3'd0, 32'hFEED_FACE, 16'h0); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete(); exp_err = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 16'h0);
    @(negedge clk);
    chk("arst_hold_valid", 32'(out_valid), 32'd0);
    reset_n = 1'b1; out_ready = 1'b1;
    drive(1'b1, 3'b011, 32'h0, 16'h7FFF); tick();
    chk("post_rst_sh2", out_data, 32'h0001FFFC);
    drive(1'b0, 3'd0, 32'h0, 16'h0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
